// File: rtl/logs_pwm_decoder_pkg.sv
// Shared constants for the PWM audio decoder.
// State encodings are kept here so other input tiles can reuse them.
package logs_pwm_decoder_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/logs_pwm_decoder_sync.sv
// N-stage single-bit synchronizer with asynchronous reset to 0.
// Reusable by any tile that samples an asynchronous line.
module logs_sync #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[N-2:0], i_d};
    end
  end

  assign o_q = r_sh[N-1];

endmodule

// File: rtl/logs_pwm_decoder.sv
// PWM audio receiver: aligns a 2^K window to rising edges of the line
// and reports the number of high cycles per window once locked.
module logs_pwm_decoder
  import logs_pwm_decoder_pkg::*;
#(
  parameter int K           = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         audio_in,
  output logic [K:0]   level_out,
  output logic         level_valid,
  output logic         locked
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [K-1:0]  PH_ONE  = K'(1);
  localparam logic [K-1:0]  PH_LAST = '1;
  localparam logic [K:0]    HI_ONE  = (K + 1)'(1);
  localparam logic [GW-1:0] GD_LOCK = GW'(LOCK_COUNT);
  localparam logic [GW-1:0] GD_ONE  = GW'(1);

  logic          w_s;
  logic          w_rise;
  logic          w_slip;
  logic          w_end;
  logic [K:0]    w_final;
  logic [GW-1:0] w_good_nxt;

  logic          r_s_d;
  logic [K-1:0]  r_phase;
  logic [K:0]    r_hi;
  logic [GW-1:0] r_good;
  logic [1:0]    r_state;
  logic [K:0]    r_level;
  logic          r_valid;
  logic          r_locked;

  logs_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (audio_in),
    .o_q   (w_s)
  );

  assign w_rise     = w_s & ~r_s_d;
  assign w_slip     = w_rise && (r_phase != '0);
  assign w_end      = (r_phase == PH_LAST);
  assign w_final    = r_hi + {{K{1'b0}}, w_s};
  assign w_good_nxt = r_good + GD_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_d    <= 1'b0;
      r_phase  <= '0;
      r_hi     <= '0;
      r_good   <= '0;
      r_state  <= ST_SEARCH;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_s_d   <= w_s;
      r_valid <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_rise) begin
            r_phase <= PH_ONE;
            r_hi    <= HI_ONE;
            r_good  <= '0;
            r_state <= ST_TRACK;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          // A rise away from phase 0 means we lost alignment: restart here.
          if (w_slip) begin
            r_phase  <= PH_ONE;
            r_hi     <= HI_ONE;
            r_good   <= '0;
            r_state  <= ST_TRACK;
            r_locked <= 1'b0;
          end else begin
            r_phase <= r_phase + PH_ONE;
            if (w_end) begin
              r_hi <= '0;
              if (r_state == ST_TRACK) begin
                if (w_good_nxt >= GD_LOCK) begin
                  r_good   <= GD_LOCK;
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                end else begin
                  r_good <= w_good_nxt;
                end
              end else begin
                r_level <= w_final;
                r_valid <= 1'b1;
              end
            end else begin
              r_hi <= w_final;
            end
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign level_out   = r_level;
  assign level_valid = r_valid;
  assign locked      = r_locked;

endmodule

// File: tb/tb_logs_pwm_decoder.sv
// Directed plus randomized bench for logs_pwm_decoder (K=2 and K=1 builds).
// Expected levels come from the duty of the PWM pattern being driven.
module tb_logs_pwm_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       audio_in;
  logic [2:0] level_out;
  logic       level_valid;
  logic       locked;

  logic       audio1;
  logic [1:0] level1;
  logic       valid1;
  logic       locked1;

  int n_tests = 0;
  int n_fail  = 0;

  int cnt0 = 0, cnt1 = 0;
  int skip0 = 0, skip1 = 0;
  int exp0 = 0, exp1 = 0;
  bit chk0 = 0, chk1 = 0;
  bit g_unl = 0;
  int bad_strobe = 0;

  always #5 clk = ~clk;

  logs_pwm_decoder #(.K(2), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .audio_in    (audio_in),
    .level_out   (level_out),
    .level_valid (level_valid),
    .locked      (locked)
  );

  logs_pwm_decoder #(.K(1), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .audio_in    (audio1),
    .level_out   (level1),
    .level_valid (valid1),
    .locked      (locked1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit a0, input bit a1);
    audio_in = a0;
    audio1   = a1;
    @(posedge clk);
    #1;
    if (!locked) g_unl = 1;
    if (level_valid) begin
      cnt0++;
      if (!locked) bad_strobe++;
      if (chk0) begin
        if (skip0 > 0) skip0--;
        else chk("level_k2", level_out, exp0);
      end
    end
    if (valid1) begin
      cnt1++;
      if (!locked1) bad_strobe++;
      if (chk1) begin
        if (skip1 > 0) skip1--;
        else chk("level_k1", level1, exp1);
      end
    end
  endtask

  // One 4-cycle window: high for the first d cycles.
  task automatic window(input int d);
    for (int i = 0; i < 4; i++) step(i < d, 1'b0);
  endtask

  task automatic run(input int d, input int nwin, input bit exact);
    exp0  = d;
    skip0 = 1;
    chk0  = 1;
    cnt0  = 0;
    repeat (nwin) window(d);
    if (exact) begin
      chk("strobe_count", cnt0, nwin);
      chk("lock_held", locked, 1);
    end
  endtask

  task automatic run1(input int nwin, input bit exact);
    exp1  = 1;
    skip1 = 1;
    chk1  = 1;
    cnt1  = 0;
    repeat (nwin) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    if (exact) begin
      chk("k1_strobe_count", cnt1, nwin);
      chk("k1_locked", locked1, 1);
    end
  endtask

  initial begin
    int d, nw;
    audio_in = 1'b1;
    audio1   = 1'b0;
    reset    = 1'b1;
    #2;
    chk("rst_level", level_out, 0);
    chk("rst_valid", level_valid, 0);
    chk("rst_locked", locked, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    cnt0 = 0;
    repeat (6) step(1'b1, 1'b0);
    chk("no_strobe_prelock", cnt0, 0);
    chk("not_locked_prelock", locked, 0);

    // Duty 2/4 until lock, bounded.
    for (int w = 0; w < 12 && !locked; w++) window(2);
    chk("lock_acquired", locked, 1);
    run(2, 2, 0);
    run(2, 4, 1);

    // Level change while locked.
    run(1, 6, 1);

    for (int p = 0; p < 6; p++) begin
      d  = $urandom_range(0, 4);
      nw = $urandom_range(3, 6);
      run(d, nw, 1);
    end

    // Constant low then constant high.
    run(0, 10, 1);
    run(4, 10, 1);

    // Extra rise at phase 2 forces a slip.
    run(2, 3, 1);
    chk0  = 0;
    g_unl = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    cnt0 = 0;
    window(2);
    chk("slip_no_strobe", cnt0, 0);
    chk("slip_unlock", g_unl, 1);
    run(2, 8, 0);
    run(2, 4, 1);

    // Asynchronous reset mid-window.
    run(2, 3, 1);
    chk("pre_reset_level", level_out, 2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_level", level_out, 0);
    chk("async_valid", level_valid, 0);
    chk("async_locked", locked, 0);
    chk0 = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    run(2, 12, 0);
    run(2, 4, 1);

    // K=1 build at duty 1/2.
    chk0 = 0;
    run1(10, 0);
    run1(4, 1);

    chk("strobe_only_when_locked", bad_strobe, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
